cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 42 ++++
 rtl/cdb_arbiter_rr_pick.sv | 35 +++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the Common Data Bus arbiter.
// Covers the tagged FU payload, the CDB bus record, FU tag codes and the arbiter state.
package cdb_arbiter_pkg;

   localparam int NUM_SRBITS = 8;
   localparam int DATA_W     = 32;

   localparam logic [NUM_SRBITS-1:0] TAG_NONE = 8'h00;
   localparam logic [NUM_SRBITS-1:0] TAG_ALU0 = 8'h10;
   localparam logic [NUM_SRBITS-1:0] TAG_ALU1 = 8'h11;
   localparam logic [NUM_SRBITS-1:0] TAG_MUL  = 8'h18;
   localparam logic [NUM_SRBITS-1:0] TAG_DIV  = 8'h13;
   localparam logic [NUM_SRBITS-1:0] TAG_LSU  = 8'h14;

   typedef struct packed {
      logic [NUM_SRBITS-1:0] tag;
      logic [DATA_W-1:0]     val;
   } tagged_data_t;

   typedef struct packed {
      logic                  valid;
      logic [NUM_SRBITS-1:0] tag;
      logic [DATA_W-1:0]     data;
   } cdb_bus_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BCAST = 1'b1
   } cdb_state_e;

   // Single conditional subtract is enough because callers never exceed 2*n-1.
   function automatic int wrap_idx(input int i, input int n);
      int r;
      if (i >= n) begin
         r = i - n;
      end else begin
         r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: scans upward from ptr_i+1 with wrap
// and reports the first set request as one-hot, index and any-flag.
module cdb_arbiter_rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // First requester at or after ptr_i+1 wins; later hits are masked by any_o.
   always_comb begin
      int k;
      k      = 0;
      pick_o = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         k = wrap_idx(int'(ptr_i) + i, NUM_REQ);
         if (!any_o && req_i[k]) begin
            pick_o[k] = 1'b1;
            idx_o     = IDX_W'(k);
            any_o     = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among FU requesters with a
// one-cycle holdoff on the last winner, registered bus and broadcast counter.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_i,
   input  tagged_data_t [NUM_REQ-1:0]    data_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output cdb_bus_t                      cdb_o,
   output logic [15:0]                   bcast_cnt_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   cdb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]      holdoff_q, holdoff_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [NUM_SRBITS-1:0]   tag_q, tag_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic [15:0]             cnt_q, cnt_d;

   logic [NUM_REQ-1:0]      qual_s;
   logic [NUM_REQ-1:0]      pick_s;
   logic [IDX_W-1:0]        pick_idx_s;
   logic                    pick_any_s;

   assign qual_s = req_i & ~holdoff_q;

   cdb_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i   (qual_s),
      .ptr_i   (rr_ptr_q),
      .pick_o  (pick_s),
      .idx_o   (pick_idx_s),
      .any_o   (pick_any_s)
   );

   // State and datapath registers; reset clears the bus so valid drops at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
         holdoff_q <= '0;
         grant_q   <= '0;
         tag_q     <= '0;
         data_q    <= '0;
         cnt_q     <= 16'h0000;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         holdoff_q <= holdoff_d;
         grant_q   <= grant_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next state: BCAST only while a non-flushed qualifying request exists.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else if (pick_any_s) begin
         state_d = ST_BCAST;
      end else begin
         state_d = ST_IDLE;
      end
   end

   // Datapath next values; data holds across idle cycles, tag returns to zero.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      holdoff_d = '0;
      grant_d   = '0;
      tag_d     = TAG_NONE;
      data_d    = data_q;
      cnt_d     = cnt_q;
      if (!flush && pick_any_s) begin
         rr_ptr_d  = pick_idx_s;
         holdoff_d = pick_s;
         grant_d   = pick_s;
         tag_d     = data_i[pick_idx_s].tag;
         data_d    = data_i[pick_idx_s].val;
         cnt_d     = cnt_q + 16'd1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      cdb_o.valid = (state_q == ST_BCAST);
      cdb_o.tag   = tag_q;
      cdb_o.data  = data_q;
      grant_o     = grant_q;
      bcast_cnt_o = cnt_q;
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for the steady-state cases
// followed by hand-written sequences for flush, fairness, async reset and counter wrap.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush;
   logic [N-1:0]           req_i;
   tagged_data_t [N-1:0]   data_i;
   logic [N-1:0]           grant_o;
   cdb_bus_t               cdb_o;
   logic [15:0]            bcast_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [N-1:0] req;
      logic         flush;
      logic         exp_valid;
      logic [N-1:0] exp_grant;
      logic [7:0]   exp_tag;
      logic [31:0]  exp_data;
   } vec_t;

   vec_t vecs[11];

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req_i       (req_i),
      .data_i      (data_i),
      .grant_o     (grant_o),
      .cdb_o       (cdb_o),
      .bcast_cnt_o (bcast_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change at negedge; one posedge passes; outputs sampled at next negedge.
   task automatic cyc(input logic [N-1:0] r, input logic f);
      req_i = r;
      flush = f;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      req_i = '0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_data();
      data_i[0] = '{tag: 8'h10, val: 32'h1111_0000};
      data_i[1] = '{tag: 8'h11, val: 32'h2222_0000};
      data_i[2] = '{tag: 8'h18, val: 32'hDEAD_BEEF};
      data_i[3] = '{tag: 8'h13, val: 32'h4444_0000};
      data_i[4] = '{tag: 8'h14, val: 32'h5555_0000};
   endtask

   initial begin
      logic [N-1:0] eg;

      vecs[0]  = '{5'b00100, 1'b0, 1'b1, 5'b00100, 8'h18, 32'hDEAD_BEEF};
      vecs[1]  = '{5'b00000, 1'b0, 1'b0, 5'b00000, 8'h00, 32'hDEAD_BEEF};
      vecs[2]  = '{5'b00010, 1'b0, 1'b1, 5'b00010, 8'h11, 32'h2222_0000};
      vecs[3]  = '{5'b00010, 1'b0, 1'b0, 5'b00000, 8'h00, 32'h2222_0000};
      vecs[4]  = '{5'b00010, 1'b0, 1'b1, 5'b00010, 8'h11, 32'h2222_0000};
      vecs[5]  = '{5'b01001, 1'b1, 1'b0, 5'b00000, 8'h00, 32'h2222_0000};
      vecs[6]  = '{5'b01001, 1'b0, 1'b1, 5'b01000, 8'h13, 32'h4444_0000};
      vecs[7]  = '{5'b01001, 1'b0, 1'b1, 5'b00001, 8'h10, 32'h1111_0000};
      vecs[8]  = '{5'b10001, 1'b0, 1'b1, 5'b10000, 8'h14, 32'h5555_0000};
      vecs[9]  = '{5'b10001, 1'b0, 1'b1, 5'b00001, 8'h10, 32'h1111_0000};
      vecs[10] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 8'h00, 32'h1111_0000};

      load_data();
      rst   = 1'b0;
      req_i = '0;
      flush = 1'b0;
      @(negedge clk);
      chk("rst_valid", 40'(cdb_o.valid), 40'd0);
      chk("rst_grant", 40'(grant_o), 40'd0);
      chk("rst_tag",   40'(cdb_o.tag), 40'd0);
      chk("rst_data",  40'(cdb_o.data), 40'd0);
      chk("rst_cnt",   40'(bcast_cnt_o), 40'd0);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven steady-state vectors.
      for (int i = 0; i < 11; i++) begin
         cyc(vecs[i].req, vecs[i].flush);
         chk($sformatf("v%0d_valid", i), 40'(cdb_o.valid), 40'(vecs[i].exp_valid));
         chk($sformatf("v%0d_grant", i), 40'(grant_o),     40'(vecs[i].exp_grant));
         chk($sformatf("v%0d_tag", i),   40'(cdb_o.tag),   40'(vecs[i].exp_tag));
         chk($sformatf("v%0d_data", i),  40'(cdb_o.data),  40'(vecs[i].exp_data));
      end
      chk("table_cnt", 40'(bcast_cnt_o), 40'd7);

      // Flush on the first grant cycle leaves rr_ptr at its reset value.
      do_reset();
      cyc(5'b01001, 1'b1);
      chk("flush_valid", 40'(cdb_o.valid), 40'd0);
      chk("flush_grant", 40'(grant_o), 40'd0);
      chk("flush_cnt",   40'(bcast_cnt_o), 40'd0);
      cyc(5'b01001, 1'b0);
      chk("postflush_grant", 40'(grant_o), 40'(5'b00001));
      chk("postflush_cnt",   40'(bcast_cnt_o), 40'd1);

      // Payload change after the grant edge must not reach the bus.
      data_i[0].val = 32'h0BAD_F00D;
      req_i = '0;
      #2;
      chk("capture_mid", 40'(cdb_o.data), 40'(32'h1111_0000));
      @(posedge clk);
      @(negedge clk);
      chk("capture_idle_data",  40'(cdb_o.data), 40'(32'h1111_0000));
      chk("capture_idle_valid", 40'(cdb_o.valid), 40'd0);
      load_data();

      // All requesters held: strict rotation starting at index 0.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(5'b11111, 1'b0);
         eg = N'(1 << (i % N));
         chk($sformatf("rr%0d_grant", i), 40'(grant_o), 40'(eg));
         chk($sformatf("rr%0d_valid", i), 40'(cdb_o.valid), 40'd1);
      end
      chk("rr_cnt", 40'(bcast_cnt_o), 40'd10);

      // Reset asserted between edges while a broadcast is on the bus.
      cyc(5'b00100, 1'b0);
      chk("pre_areset_valid", 40'(cdb_o.valid), 40'd1);
      #1 rst = 1'b0;
      #1;
      chk("areset_valid", 40'(cdb_o.valid), 40'd0);
      chk("areset_grant", 40'(grant_o), 40'd0);
      chk("areset_cnt",   40'(bcast_cnt_o), 40'd0);
      req_i = '0;
      @(negedge clk);
      rst = 1'b1;

      // Counter wrap: 0xFFFE broadcasts, then two more.
      req_i = 5'b11111;
      flush = 1'b0;
      repeat (16'hFFFE) @(posedge clk);
      @(negedge clk);
      chk("cnt_fffe", 40'(bcast_cnt_o), 40'h0_FFFE);
      @(posedge clk);
      @(negedge clk);
      chk("cnt_ffff", 40'(bcast_cnt_o), 40'h0_FFFF);
      @(posedge clk);
      @(negedge clk);
      chk("cnt_wrap", 40'(bcast_cnt_o), 40'h0_0000);
      req_i = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
